// File: rtl/nes_ctrl_pkg.sv
// Shared types, addresses and keycode maps for the NES joypad ports.
// Also holds the keycode decode and D-pad filter helpers.
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    BTN_RIGHT  = 3'd0,
    BTN_LEFT   = 3'd1,
    BTN_DOWN   = 3'd2,
    BTN_UP     = 3'd3,
    BTN_START  = 3'd4,
    BTN_SELECT = 3'd5,
    BTN_B      = 3'd6,
    BTN_A      = 3'd7
  } btn_e;

  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  localparam int MAX_SLOTS = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sel;
    logic [7:0] start;
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] left;
    logic [7:0] right;
    logic [7:0] turbo_a;
    logic [7:0] turbo_b;
  } keymap_t;

  // HID usage IDs: J K I O W S A D U L
  localparam keymap_t KEYMAP0 = '{
    a: 8'h0D, b: 8'h0E, sel: 8'h0C, start: 8'h12,
    up: 8'h1A, down: 8'h16, left: 8'h04, right: 8'h07,
    turbo_a: 8'h18, turbo_b: 8'h0F
  };

  // N M RShift Enter, arrows, comma period
  localparam keymap_t KEYMAP1 = '{
    a: 8'h11, b: 8'h10, sel: 8'hE5, start: 8'h28,
    up: 8'h52, down: 8'h51, left: 8'h50, right: 8'h4F,
    turbo_a: 8'h36, turbo_b: 8'h37
  };

  function automatic logic key_hit(
    input logic [8*MAX_SLOTS-1:0] keys,
    input logic [7:0]             code
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (code != 8'h00 && keys[8*i +: 8] == code)
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [7:0] decode(
    input logic [8*MAX_SLOTS-1:0] keys,
    input keymap_t                m
  );
    logic [7:0] d;
    d            = 8'h00;
    d[BTN_A]     = key_hit(keys, m.a);
    d[BTN_B]     = key_hit(keys, m.b);
    d[BTN_SELECT]= key_hit(keys, m.sel);
    d[BTN_START] = key_hit(keys, m.start);
    d[BTN_UP]    = key_hit(keys, m.up);
    d[BTN_DOWN]  = key_hit(keys, m.down);
    d[BTN_LEFT]  = key_hit(keys, m.left);
    d[BTN_RIGHT] = key_hit(keys, m.right);
    return d;
  endfunction

  // Opposing directions cancel rather than confuse games.
  function automatic logic [7:0] dpad_filter(input logic [7:0] p);
    logic [7:0] f;
    f = p;
    if (p[BTN_UP] && p[BTN_DOWN]) begin
      f[BTN_UP]   = 1'b0;
      f[BTN_DOWN] = 1'b0;
    end
    if (p[BTN_LEFT] && p[BTN_RIGHT]) begin
      f[BTN_LEFT]  = 1'b0;
      f[BTN_RIGHT] = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/nes_ctrl_shift.sv
// One pad's 8-bit latch/shift register; shifts in 1s so reads 9+ return 1.
module nes_ctrl_shift
  import nes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] pad,
  output logic       q
);

  logic [7:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sr <= 8'h00;
    else if (load)
      sr <= pad;
    else if (shift)
      sr <= {sr[6:0], 1'b1};
  end

  assign q = sr[7];

endmodule

// File: rtl/nes_controller_ports.sv
// NES joypad ports at $4016/$4017: HID keycode decode, turbo,
// D-pad filter, strobe latch and serial read-out to the CPU.
module nes_controller_ports
  import nes_ctrl_pkg::*;
#(
  parameter int         NUM_PORTS   = 2,
  parameter int         KEY_SLOTS   = 4,
  parameter int         TURBO_EN    = 1,
  parameter int         TURBO_DIV   = 833_333,
  parameter int         DPAD_FILTER = 1,
  parameter logic [6:0] OPEN_BUS_HI = 7'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            addr,
  input  logic                   wren,
  input  logic                   rden,
  input  logic [7:0]             din,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  output logic [7:0]             dout,
  output logic                   strobe_o
);

  localparam int CW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic                     strobe;
  logic                     rd_q;
  logic                     phase;
  logic [8*MAX_SLOTS-1:0]   keys;
  logic [7:0]               pad [2];
  logic                     ser [2];
  logic                     sel0;
  logic                     sel1;
  logic                     rd_fire;
  logic                     rd_bit;
  logic                     unused_din;

  assign keys       = (8*MAX_SLOTS)'(keycode);
  assign sel0       = (addr == ADDR_JOY1);
  assign sel1       = (addr == ADDR_JOY2);
  assign unused_din = ^din[7:1];

  // One shift per rden pulse; a coincident write wins the cycle.
  assign rd_fire = rden && !rd_q && !wren;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      rd_q <= rden;
      if (wren && sel0)
        strobe <= din[0];
    end
  end

  generate
    if (TURBO_EN != 0) begin : g_turbo
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (cnt == CW'(TURBO_DIV - 1)) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin : g_no_turbo
      assign phase = 1'b0;
    end
  endgenerate

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      if (p < NUM_PORTS) begin : g_on
        localparam keymap_t M = (p == 0) ? KEYMAP0 : KEYMAP1;
        logic [7:0] raw;
        logic       tb_a;
        logic       tb_b;

        assign tb_a = key_hit(keys, M.turbo_a) && phase;
        assign tb_b = key_hit(keys, M.turbo_b) && phase;
        assign raw  = decode(keys, M) | {tb_a, tb_b, 6'b0};
        assign pad[p] = (DPAD_FILTER != 0) ? dpad_filter(raw) : raw;

        nes_ctrl_shift u_shift (
          .clk   (clk),
          .reset (reset),
          .load  (strobe),
          .shift (rd_fire && !strobe && (p == 0 ? sel0 : sel1)),
          .pad   (pad[p]),
          .q     (ser[p])
        );
      end else begin : g_off
        assign pad[p] = 8'h00;
        assign ser[p] = 1'b0;
      end
    end
  endgenerate

  // While strobing, the read sees live A instead of the latched bit.
  always_comb begin
    rd_bit = 1'b0;
    if (strobe)
      rd_bit = sel1 ? pad[1][BTN_A] : pad[0][BTN_A];
    else
      rd_bit = sel1 ? ser[1] : ser[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dout <= 8'h00;
    else if (rd_fire && (sel0 || sel1))
      dout <= {OPEN_BUS_HI, rd_bit};
  end

  assign strobe_o = strobe;

endmodule
